adcdac_2g_cmd_seq: RTL and testbench

ADCDAC_2G_CMD_SEQ -- requirements
Module: adcdac_2g_cmd_seq

---
 rtl/adcdac_2g_cmd_seq.sv | 176 +++++++++++++++++
 tb/tb_adcdac_2g_cmd_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adcdac_2g_cmd_seq.sv
// rtl/adcdac_2g_cmd_seq.sv - register command sequencer over a byte-wide serial link
// Optional read-response timeout: ADCDAC_CMD_TIMEOUT_EN
module adcdac_2g_cmd_seq #(
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        fpga_clk,
    input  logic        fpga_rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rd,
    input  logic [6:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_timeout,
    input  logic        relink,
    output logic        busy,
    output logic [7:0]  rx_drop_cnt,
    output logic        user_tx_rst,
    output logic        user_rx_rst,
    output logic [7:0]  user_tx_data,
    output logic        user_tx_val,
    input  logic        user_tx_full,
    input  logic [7:0]  user_rx_data,
    input  logic        user_rx_val
);

    localparam logic [2:0] LINK_RST = 3'd0;
    localparam logic [2:0] IDLE     = 3'd1;
    localparam logic [2:0] TX_HDR   = 3'd2;
    localparam logic [2:0] TX_DHI   = 3'd3;
    localparam logic [2:0] TX_DLO   = 3'd4;
    localparam logic [2:0] RX_HI    = 3'd5;
    localparam logic [2:0] RX_LO    = 3'd6;
    localparam logic [2:0] DONE     = 3'd7;

    localparam int RW = $clog2(RST_CYCLES + 1);

    logic [2:0]    state;
    logic [RW-1:0] rst_cnt;
    logic          cmd_rd;
    logic [6:0]    cmd_addr;
    logic [15:0]   cmd_wdata;
    logic [7:0]    rx_hi;
    logic          in_rx;
    logic          in_tx;
    logic          timeout_hit;
    logic          timeout_done;

    assign in_rx        = (state == RX_HI) || (state == RX_LO);
    assign in_tx        = (state == TX_HDR) || (state == TX_DHI) || (state == TX_DLO);
    assign timeout_done = in_rx && !user_rx_val && timeout_hit;

`ifdef ADCDAC_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;
    logic          enter_done;
    logic          rsp_timeout_q;

    // Restarts on RX entry (counter is held clear outside RX) and on every captured byte.
    always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            to_cnt <= '0;
        end else if (!in_rx || user_rx_val) begin
            to_cnt <= '0;
        end else if (!timeout_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign enter_done  = (state == TX_DLO && !user_tx_full) ||
                         (state == RX_LO && user_rx_val) || timeout_done;

    always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            rsp_timeout_q <= 1'b0;
        end else if (enter_done) begin
            rsp_timeout_q <= timeout_done;
        end
    end

    assign rsp_timeout = rsp_timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            state       <= LINK_RST;
            rst_cnt     <= '0;
            cmd_rd      <= 1'b0;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            rx_hi       <= '0;
            rsp_rdata   <= '0;
            rx_drop_cnt <= '0;
        end else begin
            if (user_rx_val && !in_rx && rx_drop_cnt != 8'hFF) begin
                rx_drop_cnt <= rx_drop_cnt + 8'd1;
            end
            case (state)
                LINK_RST: begin
                    if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                        state   <= IDLE;
                        rst_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    // An accepted request takes priority over a simultaneous relink.
                    if (req_valid) begin
                        cmd_rd    <= req_rd;
                        cmd_addr  <= req_addr;
                        cmd_wdata <= req_wdata;
                        state     <= TX_HDR;
                    end else if (relink) begin
                        state       <= LINK_RST;
                        rst_cnt     <= '0;
                        rx_drop_cnt <= '0;
                    end
                end
                TX_HDR: if (!user_tx_full) state <= cmd_rd ? RX_HI : TX_DHI;
                TX_DHI: if (!user_tx_full) state <= TX_DLO;
                TX_DLO: begin
                    if (!user_tx_full) begin
                        state     <= DONE;
                        rsp_rdata <= '0;
                    end
                end
                RX_HI: begin
                    if (user_rx_val) begin
                        rx_hi <= user_rx_data;
                        state <= RX_LO;
                    end else if (timeout_hit) begin
                        state     <= DONE;
                        rsp_rdata <= '0;
                    end
                end
                RX_LO: begin
                    if (user_rx_val) begin
                        rsp_rdata <= {rx_hi, user_rx_data};
                        state     <= DONE;
                    end else if (timeout_hit) begin
                        state     <= DONE;
                        rsp_rdata <= '0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= LINK_RST;
            endcase
        end
    end

    assign req_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign user_tx_rst = (state == LINK_RST);
    assign user_rx_rst = (state == LINK_RST);
    assign rsp_valid   = (state == DONE);
    assign user_tx_val = in_tx && !user_tx_full;

    always_comb begin
        user_tx_data = 8'h00;
        case (state)
            TX_HDR:  user_tx_data = {cmd_rd, cmd_addr};
            TX_DHI:  user_tx_data = cmd_wdata[15:8];
            TX_DLO:  user_tx_data = cmd_wdata[7:0];
            default: user_tx_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_adcdac_2g_cmd_seq.sv
// tb/tb_adcdac_2g_cmd_seq.sv - self-checking bench for adcdac_2g_cmd_seq
module tb_adcdac_2g_cmd_seq;

    logic        fpga_clk;
    logic        fpga_rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_rd;
    logic [6:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_timeout;
    logic        relink;
    logic        busy;
    logic [7:0]  rx_drop_cnt;
    logic        user_tx_rst;
    logic        user_rx_rst;
    logic [7:0]  user_tx_data;
    logic        user_tx_val;
    logic        user_tx_full;
    logic [7:0]  user_rx_data;
    logic        user_rx_val;

    adcdac_2g_cmd_seq dut (
        .fpga_clk     (fpga_clk),
        .fpga_rst_n   (fpga_rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rd       (req_rd),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_timeout  (rsp_timeout),
        .relink       (relink),
        .busy         (busy),
        .rx_drop_cnt  (rx_drop_cnt),
        .user_tx_rst  (user_tx_rst),
        .user_rx_rst  (user_rx_rst),
        .user_tx_data (user_tx_data),
        .user_tx_val  (user_tx_val),
        .user_tx_full (user_tx_full),
        .user_rx_data (user_rx_data),
        .user_rx_val  (user_rx_val)
    );

    initial fpga_clk = 1'b0;
    always #5 fpga_clk = ~fpga_clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rsp_n = 0;
    int          rsp_cyc = 0;
    logic [15:0] rsp_d = '0;
    logic        rsp_to = 1'b0;
    int          full_viol = 0;
    logic [7:0]  txq[$];
    int          txc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe outputs mid-cycle, then return just after the next rising edge.
    task automatic cycle();
        @(negedge fpga_clk);
        cyc++;
        if (user_tx_val) begin
            txq.push_back(user_tx_data);
            txc.push_back(cyc);
            if (user_tx_full) full_viol++;
        end
        if (rsp_valid) begin
            rsp_n++;
            rsp_cyc = cyc;
            rsp_d   = rsp_rdata;
            rsp_to  = rsp_timeout;
        end
        @(posedge fpga_clk);
        #1;
    endtask

    task automatic count_link_rst(input string tag);
        int n;
        n = 0;
        while (user_tx_rst && user_rx_rst && n < 100) begin
            cycle();
            n++;
        end
        check(tag, n, 16);
        check({tag, "_ready"}, req_ready, 1);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Transaction model: bytes leave after full_n stalled cycles, response timing follows from rx gaps.
    task automatic issue(input logic rd, input logic [6:0] addr, input logic [15:0] wd,
                         input int full_n, input int d1, input int d2,
                         input logic [7:0] hi, input logic [7:0] lo, input logic with_relink);
        int          n;
        int          acc;
        int          done_cyc;
        logic [7:0]  exp_b[$];
        logic [15:0] exp_d;
        n = 0;
        while (!req_ready && n < 200) begin
            cycle();
            n++;
        end
        check("ready_before_req", req_ready, 1);
        txq.delete();
        txc.delete();
        rsp_n = 0;
        req_valid = 1'b1; req_rd = rd; req_addr = addr; req_wdata = wd; relink = with_relink;
        cycle();
        acc = cyc;
        req_valid = 1'b0; relink = 1'b0;
        req_rd = 1'($urandom); req_addr = 7'($urandom); req_wdata = 16'($urandom);
        check("no_relink_on_accept", user_tx_rst, 0);
        for (int i = 0; i < full_n; i++) begin
            user_tx_full = 1'b1;
            cycle();
        end
        user_tx_full = 1'b0;
        cycle();
        if (rd) begin
            repeat (d1) cycle();
            user_rx_val = 1'b1; user_rx_data = hi;
            cycle();
            user_rx_val = 1'b0;
            repeat (d2) cycle();
            user_rx_val = 1'b1; user_rx_data = lo;
            cycle();
            user_rx_val = 1'b0;
        end
        n = 0;
        while (rsp_n == 0 && n < 50) begin
            cycle();
            n++;
        end
        exp_b.push_back({rd, addr});
        if (!rd) begin
            exp_b.push_back(wd[15:8]);
            exp_b.push_back(wd[7:0]);
        end
        exp_d    = rd ? {hi, lo} : 16'h0000;
        done_cyc = rd ? acc + 4 + full_n + d1 + d2 : acc + 4 + full_n;
        check("tx_count", txq.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < txq.size(); i++) begin
            check("tx_byte", txq[i], exp_b[i]);
            check("tx_cycle", txc[i], acc + 1 + full_n + i);
        end
        check("rsp_cycle", rsp_cyc, done_cyc);
        check("rsp_rdata", rsp_d, exp_d);
        check("rsp_timeout", rsp_to, 0);
        repeat (2) cycle();
        check("rsp_once", rsp_n, 1);
        check("rsp_hold", rsp_rdata, exp_d);
    endtask

    initial begin
        int n;
        int acc;
        int tx_before;
        fpga_rst_n = 1'b0; req_valid = 1'b0; req_rd = 1'b0; req_addr = '0; req_wdata = '0;
        relink = 1'b0; user_tx_full = 1'b0; user_rx_data = '0; user_rx_val = 1'b0;
        repeat (3) cycle();
        check("rst_tx_rst", user_tx_rst, 1);
        check("rst_rx_rst", user_rx_rst, 1);
        check("rst_busy", busy, 1);
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_tx_val", user_tx_val, 0);
        check("rst_tx_data", user_tx_data, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_drop", rx_drop_cnt, 0);
        fpga_rst_n = 1'b1;
        count_link_rst("link_rst_cycles");

        issue(1'b0, 7'h15, 16'hBEEF, 0, 0, 0, 8'h00, 8'h00, 1'b0);
        issue(1'b1, 7'h03, 16'h0000, 5, 0, 0, 8'h12, 8'h34, 1'b0);
        issue(1'b0, 7'h7F, 16'h0001, 2, 0, 0, 8'h00, 8'h00, 1'b1);
        for (int k = 0; k < 20; k++) begin
            issue(1'($urandom_range(0, 1)), 7'($urandom), 16'($urandom), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), 8'($urandom), 8'($urandom), 1'b0);
        end
        check("drop_after_cmds", rx_drop_cnt, 0);

        for (int i = 0; i < 300; i++) begin
            user_rx_val = 1'b1; user_rx_data = 8'($urandom);
            cycle();
            if (i == 99) check("drop_100", rx_drop_cnt, 100);
        end
        user_rx_val = 1'b0;
        check("drop_saturate", rx_drop_cnt, 255);
        check("drop_idle", busy, 0);
        relink = 1'b1;
        cycle();
        relink = 1'b0;
        check("relink_drop_clear", rx_drop_cnt, 0);
        count_link_rst("relink_cycles");

`ifdef ADCDAC_CMD_TIMEOUT_EN
        rsp_n = 0;
        req_valid = 1'b1; req_rd = 1'b1; req_addr = 7'h22;
        cycle();
        acc = cyc;
        req_valid = 1'b0;
        n = 0;
        while (rsp_n == 0 && n < 5000) begin
            cycle();
            n++;
        end
        check("timeout_cycle", rsp_cyc, acc + 2 + 4096);
        check("timeout_flag", rsp_to, 1);
        check("timeout_rdata", rsp_d, 0);
`endif

        txq.delete();
        txc.delete();
        rsp_n = 0;
        req_valid = 1'b1; req_rd = 1'b0; req_addr = 7'h55; req_wdata = 16'hA5C3;
        cycle();
        req_valid = 1'b0;
        cycle();
        tx_before = txq.size();
        check("abort_hdr_sent", tx_before, 1);
        fpga_rst_n = 1'b0;
        repeat (3) cycle();
        check("abort_tx_rst", user_tx_rst, 1);
        fpga_rst_n = 1'b1;
        count_link_rst("abort_link_rst");
        check("abort_no_tx", txq.size(), tx_before);
        check("abort_no_rsp", rsp_n, 0);
        issue(1'b1, 7'h41, 16'h0000, 1, 2, 1, 8'hC0, 8'hDE, 1'b0);

        check("tx_while_full", full_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
